// File: rtl/execute_md.sv
// Execute stage: operand forwarding, immediate select, ALU and an
// iterative radix-2 multiply/divide unit that owns HI/LO.
module execute_md #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       forwardAE,
    input  logic [1:0]       forwardBE,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    input  logic [WIDTH-1:0] ALUOutM,
    input  logic [WIDTH-1:0] ResultW,
    input  logic [WIDTH-1:0] SignImmE,
    input  logic [WIDTH-1:0] ZeroImmE,
    input  logic [1:0]       ALUSrcE,
    input  logic [2:0]       ALUControlE,
    input  logic             RegDstE,
    input  logic [REGW-1:0]  RtE,
    input  logic [REGW-1:0]  RdE,
    input  logic             MdStartE,
    input  logic [1:0]       MdOpE,
    input  logic [1:0]       HiLoSelE,
    output logic [REGW-1:0]  WriteRegE,
    output logic [WIDTH-1:0] WriteDataE,
    output logic [WIDTH-1:0] ALUOutE,
    output logic             ZeroE,
    output logic             MdBusy,
    output logic             StallE
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } md_state_e;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] alu_res;

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic             nega_q, nega_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;

    always_comb begin
        if (forwardAE[1]) begin
            src_a = ALUOutM;
        end else if (forwardAE[0]) begin
            src_a = ResultW;
        end else begin
            src_a = rd1;
        end
        if (forwardBE[1]) begin
            fwd_b = ALUOutM;
        end else if (forwardBE[0]) begin
            fwd_b = ResultW;
        end else begin
            fwd_b = rd2;
        end
        unique case (ALUSrcE)
            2'b00:   src_b = fwd_b;
            2'b10:   src_b = ZeroImmE;
            default: src_b = SignImmE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        unique case (ALUControlE)
            3'b000: alu_res = src_a & src_b;
            3'b001: alu_res = src_a | src_b;
            3'b010: alu_res = src_a + src_b;
            3'b011: alu_res = src_a ^ src_b;
            3'b100: alu_res = ~(src_a | src_b);
            3'b101: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            3'b110: alu_res = src_a - src_b;
            3'b111: alu_res = {{(WIDTH-1){1'b0}},
                               ($signed(src_a) < $signed(src_b))};
        endcase
    end

    assign WriteRegE  = RegDstE ? RdE : RtE;
    assign WriteDataE = fwd_b;
    assign ZeroE      = (alu_res == '0);
    assign ALUOutE    = HiLoSelE[1] ? (HiLoSelE[0] ? hi_q : lo_q) : alu_res;
    assign MdBusy     = busy_q;
    assign StallE     = busy_q & (MdStartE | HiLoSelE[1]);

    // Iteration datapath: acc is the running high half / partial remainder,
    // mq holds multiplier or dividend and collects low product / quotient.
    logic             sgn;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] sub_diff;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign sgn      = MdOpE[0];
    assign a_mag    = (sgn && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_mag    = (sgn && src_b[WIDTH-1]) ? -src_b : src_b;
    assign add_sum  = {1'b0, acc_q} + ({1'b0, b_q} & {(WIDTH+1){mq_q[0]}});
    assign shl      = {acc_q, mq_q[WIDTH-1]};
    assign div_ge   = (shl >= {1'b0, b_q});
    assign sub_diff = shl[WIDTH-1:0] - b_q;
    assign prod     = {acc_q, mq_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = bzero_q ? {WIDTH{1'b1}} : (neg_q ? -mq_q : mq_q);
    assign rem_fix  = nega_q ? -acc_q : acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        b_d     = b_q;
        op_d    = op_q;
        neg_d   = neg_q;
        nega_d  = nega_q;
        bzero_d = bzero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (MdStartE) begin
                    acc_d   = '0;
                    mq_d    = a_mag;
                    b_d     = b_mag;
                    op_d    = MdOpE;
                    neg_d   = sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    nega_d  = sgn & src_a[WIDTH-1];
                    bzero_d = (src_b == '0);
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (op_q[1]) begin
                    if (div_ge) begin
                        acc_d = sub_diff;
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = shl[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = add_sum[WIDTH:1];
                    mq_d  = {add_sum[0], mq_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (op_q[1]) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            b_q     <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            nega_q  <= 1'b0;
            bzero_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            b_q     <= b_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            nega_q  <= nega_d;
            bzero_q <= bzero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_execute_md.sv
// Directed bench for execute_md: forwarding, ALU ops, immediates,
// multiply/divide results, latency, stalls and mid-operation reset.
module tb_execute_md;

    localparam int W = 32;
    localparam int R = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   forwardAE = '0;
    logic [1:0]   forwardBE = '0;
    logic [W-1:0] rd1 = '0;
    logic [W-1:0] rd2 = '0;
    logic [W-1:0] ALUOutM = '0;
    logic [W-1:0] ResultW = '0;
    logic [W-1:0] SignImmE = '0;
    logic [W-1:0] ZeroImmE = '0;
    logic [1:0]   ALUSrcE = '0;
    logic [2:0]   ALUControlE = '0;
    logic         RegDstE = 1'b0;
    logic [R-1:0] RtE = '0;
    logic [R-1:0] RdE = '0;
    logic         MdStartE = 1'b0;
    logic [1:0]   MdOpE = '0;
    logic [1:0]   HiLoSelE = '0;
    logic [R-1:0] WriteRegE;
    logic [W-1:0] WriteDataE;
    logic [W-1:0] ALUOutE;
    logic         ZeroE;
    logic         MdBusy;
    logic         StallE;

    int checks = 0;
    int errors = 0;
    int n;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    execute_md #(.WIDTH(W), .REGW(R)) dut (
        .clk(clk), .rst(rst),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .rd1(rd1), .rd2(rd2), .ALUOutM(ALUOutM), .ResultW(ResultW),
        .SignImmE(SignImmE), .ZeroImmE(ZeroImmE),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .RegDstE(RegDstE), .RtE(RtE), .RdE(RdE),
        .MdStartE(MdStartE), .MdOpE(MdOpE), .HiLoSelE(HiLoSelE),
        .WriteRegE(WriteRegE), .WriteDataE(WriteDataE),
        .ALUOutE(ALUOutE), .ZeroE(ZeroE),
        .MdBusy(MdBusy), .StallE(StallE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] ctl);
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        ALUSrcE = 2'b00;
        HiLoSelE = 2'b00;
        rd1 = a;
        rd2 = b;
        ALUControlE = ctl;
        #1;
    endtask

    task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
        HiLoSelE = 2'b11;
        #1;
        h = ALUOutE;
        HiLoSelE = 2'b10;
        #1;
        l = ALUOutE;
        HiLoSelE = 2'b00;
    endtask

    task automatic run_md(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int lat);
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        ALUSrcE = 2'b00;
        HiLoSelE = 2'b00;
        rd1 = a;
        rd2 = b;
        MdOpE = op;
        MdStartE = 1'b1;
        tick();
        MdStartE = 1'b0;
        lat = 0;
        while (MdBusy === 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #2;
        check("rst_busy", W'(MdBusy), 32'd0);
        MdStartE = 1'b1;
        HiLoSelE = 2'b10;
        #1;
        check("rst_stall", W'(StallE), 32'd0);
        MdStartE = 1'b0;
        read_hilo(hi, lo);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        tick();
        rst = 1'b1;

        rd1 = 32'd1;
        rd2 = 32'd0;
        ALUOutM = 32'd2;
        ResultW = 32'd3;
        ALUControlE = 3'b010;
        forwardAE = 2'b11;
        #1;
        check("fwdA_11", ALUOutE, 32'd2);
        forwardAE = 2'b01;
        #1;
        check("fwdA_01", ALUOutE, 32'd3);
        forwardAE = 2'b00;
        #1;
        check("fwdA_00", ALUOutE, 32'd1);
        rd2 = 32'h0000_0055;
        forwardBE = 2'b10;
        #1;
        check("fwdB_10", WriteDataE, 32'd2);
        forwardBE = 2'b01;
        #1;
        check("fwdB_01", WriteDataE, 32'd3);
        forwardBE = 2'b00;
        #1;
        check("fwdB_00", WriteDataE, 32'h0000_0055);

        alu(32'hF000_000C, 32'h0000_000A, 3'b000);
        check("and", ALUOutE, 32'h0000_0008);
        alu(32'hF000_000C, 32'h0000_000A, 3'b001);
        check("or", ALUOutE, 32'hF000_000E);
        alu(32'hF000_000C, 32'h0000_000A, 3'b010);
        check("add", ALUOutE, 32'hF000_0016);
        alu(32'hF000_000C, 32'h0000_000A, 3'b011);
        check("xor", ALUOutE, 32'hF000_0006);
        alu(32'hF000_000C, 32'h0000_000A, 3'b100);
        check("nor", ALUOutE, 32'h0FFF_FFF1);
        alu(32'hF000_000C, 32'h0000_000A, 3'b101);
        check("sltu", ALUOutE, 32'd0);
        alu(32'hF000_000C, 32'h0000_000A, 3'b110);
        check("sub", ALUOutE, 32'hF000_0002);
        check("zero_n", W'(ZeroE), 32'd0);
        alu(32'hF000_000C, 32'h0000_000A, 3'b111);
        check("slt", ALUOutE, 32'd1);
        alu(32'hFFFF_FFFF, 32'h0000_0001, 3'b010);
        check("add_wrap", ALUOutE, 32'd0);
        alu(32'h1234_5678, 32'h1234_5678, 3'b110);
        check("zero_y", W'(ZeroE), 32'd1);

        alu(32'd0, 32'd7, 3'b010);
        SignImmE = 32'hFFFF_8000;
        ZeroImmE = 32'h0000_8000;
        ALUSrcE = 2'b01;
        #1;
        check("imm_01", ALUOutE, 32'hFFFF_8000);
        ALUSrcE = 2'b10;
        #1;
        check("imm_10", ALUOutE, 32'h0000_8000);
        ALUSrcE = 2'b11;
        #1;
        check("imm_11", ALUOutE, 32'hFFFF_8000);
        check("wdata_imm", WriteDataE, 32'd7);
        RtE = 5'd5;
        RdE = 5'd9;
        RegDstE = 1'b1;
        #1;
        check("wreg_rd", W'(WriteRegE), 32'd9);
        RegDstE = 1'b0;
        #1;
        check("wreg_rt", W'(WriteRegE), 32'd5);

        run_md(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, n);
        check("mult_lat", W'(n), 32'd33);
        read_hilo(hi, lo);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);
        run_md(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, n);
        check("multu_lat", W'(n), 32'd33);
        read_hilo(hi, lo);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);
        run_md(2'b01, 32'h8000_0000, 32'h8000_0000, n);
        read_hilo(hi, lo);
        check("mult_min_hi", hi, 32'h4000_0000);
        check("mult_min_lo", lo, 32'h0000_0000);

        run_md(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, n);
        check("div_lat", W'(n), 32'd33);
        read_hilo(hi, lo);
        check("div_hi", hi, 32'hFFFF_FFFF);
        check("div_lo", lo, 32'hFFFF_FFFD);
        run_md(2'b10, 32'd7, 32'd0, n);
        check("divu0_lat", W'(n), 32'd33);
        read_hilo(hi, lo);
        check("divu0_hi", hi, 32'd7);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        run_md(2'b11, 32'hFFFF_FFF9, 32'd0, n);
        read_hilo(hi, lo);
        check("div0_hi", hi, 32'hFFFF_FFF9);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        run_md(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, n);
        read_hilo(hi, lo);
        check("divmin_hi", hi, 32'd0);
        check("divmin_lo", lo, 32'h8000_0000);
        run_md(2'b10, 32'd100, 32'd7, n);
        read_hilo(hi, lo);
        check("divu_hi", hi, 32'd2);
        check("divu_lo", lo, 32'd14);

        rd1 = 32'd3;
        rd2 = 32'd5;
        MdOpE = 2'b00;
        MdStartE = 1'b1;
        tick();
        MdStartE = 1'b0;
        HiLoSelE = 2'b10;
        #1;
        n = 0;
        while (StallE === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("mfl_stall_cnt", W'(n), 32'd33);
        check("mfl_lo", ALUOutE, 32'd15);
        HiLoSelE = 2'b00;

        rd1 = 32'd3;
        rd2 = 32'd4;
        MdStartE = 1'b1;
        tick();
        rd1 = 32'd6;
        rd2 = 32'd7;
        HiLoSelE = 2'b10;
        #1;
        n = 0;
        while (StallE === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check("b2b_stall_cnt", W'(n), 32'd33);
        check("b2b_idle", W'(MdBusy), 32'd0);
        check("b2b_old_lo", ALUOutE, 32'd12);
        tick();
        MdStartE = 1'b0;
        HiLoSelE = 2'b00;
        n = 0;
        while (MdBusy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("b2b_lat", W'(n), 32'd33);
        read_hilo(hi, lo);
        check("b2b_hi", hi, 32'd0);
        check("b2b_lo", lo, 32'd42);

        rd1 = 32'hFFFF_FFFF;
        rd2 = 32'd2;
        MdOpE = 2'b01;
        MdStartE = 1'b1;
        tick();
        MdStartE = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_busy", W'(MdBusy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", W'(MdBusy), 32'd0);
        read_hilo(hi, lo);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        alu(32'h8000_0000, 32'd1, 3'b111);
        check("arst_slt", ALUOutE, 32'd1);
        alu(32'h8000_0000, 32'd1, 3'b101);
        check("arst_sltu", ALUOutE, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        read_hilo(hi, lo);
        check("post_rst_lo", lo, 32'd0);
        run_md(2'b00, 32'd6, 32'd7, n);
        check("post_rst_lat", W'(n), 32'd33);
        read_hilo(hi, lo);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo2", lo, 32'd42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_md.md
EXECUTE_MD -- requirements
Module: execute_md

Interface
REQ-001 Parameter WIDTH, default 32: datapath width; even, >= 8.
REQ-002 Parameter REGW, default 5: register index width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 forwardAE, forwardBE  in  2 each  operand forward select; bit1 = ALUOutM, else bit0 = ResultW, else register value; bit1 wins when both set.
REQ-006 rd1, rd2, ALUOutM, ResultW  in  WIDTH each  register-file and forwarded operands.
REQ-007 SignImmE, ZeroImmE  in  WIDTH each  pre-extended immediates.
REQ-008 ALUSrcE  in  2  SrcB select: 00 forwarded B, 01 SignImmE, 10 ZeroImmE, 11 SignImmE.
REQ-009 ALUControlE  in  3  000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SLTU, 110 SUB, 111 SLT.
REQ-010 RegDstE  in  1; RtE, RdE  in  REGW  destination select and indices.
REQ-011 MdStartE  in  1  request multiply/divide this cycle.
REQ-012 MdOpE  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-013 HiLoSelE  in  2  ALUOutE source: 0x ALU, 10 LO, 11 HI.
REQ-014 WriteRegE  out  REGW  RegDstE ? RdE : RtE.
REQ-015 WriteDataE  out  WIDTH  forwarded B operand (before immediate mux).
REQ-016 ALUOutE  out  WIDTH  selected result per HiLoSelE.
REQ-017 ZeroE  out  1  ALU result == 0.
REQ-018 MdBusy  out  1  multiply/divide unit not idle.
REQ-019 StallE  out  1  execute stage must hold; upstream freezes E inputs.

Function
REQ-020 Forwarding, immediate mux, ALU, WriteRegE, WriteDataE, ZeroE: purely combinational, zero latency.
REQ-021 SLT signed compare, SLTU unsigned; result 1 or 0 zero-extended; ADD/SUB wrap modulo 2^WIDTH, no overflow flag.
REQ-022 MD FSM states: IDLE, RUN, FIN.
REQ-023 IDLE: MdStartE=1 latches SrcA, SrcB (post-mux) and MdOpE; takes magnitudes for signed ops; counter := WIDTH-1; -> RUN.
REQ-024 RUN: one radix-2 step per cycle (shift-add for MUL*, restoring shift-subtract for DIV*); counter decrements; at counter 0 -> FIN.
REQ-025 FIN: apply sign correction, write HI/LO, -> IDLE; total latency WIDTH+1 cycles from accepting edge; HI/LO readable the cycle after FIN.
REQ-026 MUL*: {HI,LO} = 2*WIDTH-bit product, signed for MULT.
REQ-027 DIV*: LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-028 Divide by zero (DIVU/DIV): LO = all ones, HI = dividend, same latency.
REQ-029 DIV MIN / -1: LO = MIN, HI = 0.
REQ-030 MdBusy = 1 in RUN and FIN, 0 in IDLE.
REQ-031 StallE = MdBusy & (MdStartE | HiLoSelE[1]); non-MD instructions never stall.
REQ-032 MdStartE while busy is not accepted; with StallE held it is accepted the first cycle in IDLE.
REQ-033 MdStartE with HiLoSelE[1] same cycle in IDLE: read returns old HI/LO, start accepted.
REQ-034 HI/LO change only in FIN; ALUOutE while StallE=1 is don't-care.

Reset
REQ-035 rst low, asynchronously: state IDLE, HI = LO = 0, counter and operand registers 0, MdBusy = StallE-contribution 0.
REQ-036 rst mid-operation aborts; HI/LO = 0, no partial result written; first start after release runs full latency.

Verification
REQ-037 Forwarding: rd1=1, ALUOutM=2, ResultW=3, forwardAE=11/01/00, ADD with B=0 -> ALUOutE 2/3/1.
REQ-038 MULT WIDTH=32: 0xFFFFFFFF x 0x00000002 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-039 DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-040 HiLoSelE=10 issued one cycle after start -> StallE high for remaining busy cycles, ALUOutE = new LO first unstalled cycle.
REQ-041 Back-to-back MdStartE -> second start stalls until IDLE, accepted there, completes WIDTH+1 cycles later.
REQ-042 rst pulsed low mid-RUN -> MdBusy 0 immediately, HI=LO=0, SLT 0x80000000 vs 1 -> ALUOutE 1, SLTU -> 0.
